// File: rtl/ens_vote_argmax_if.sv
// Handshake bundle for the ensemble vote/argmax block: member scores in, winning class out.
interface ens_vote_argmax_if #(
    parameter int N_CLASSES = 10,
    parameter int SCORE_W   = 2,
    parameter int N_MEMBERS = 4
);
    localparam int ACC_W = SCORE_W + $clog2(N_MEMBERS);
    localparam int CLS_W = (N_CLASSES > 1) ? $clog2(N_CLASSES) : 1;

    logic                         in_valid;
    logic                         in_ready;
    logic [N_CLASSES*SCORE_W-1:0] in_scores;
    logic                         out_valid;
    logic                         out_ready;
    logic [CLS_W-1:0]             out_class;
    logic [ACC_W-1:0]             out_score;

    modport master (
        output in_valid, in_scores, out_ready,
        input  in_ready, out_valid, out_class, out_score
    );

    modport slave (
        input  in_valid, in_scores, out_ready,
        output in_ready, out_valid, out_class, out_score
    );
endinterface

// File: rtl/ens_vote_argmax.sv
// Sums N_MEMBERS per-class score vectors, then scans the sums one class per cycle
// to find the argmax (lowest index wins ties) and holds it until taken downstream.
module ens_vote_argmax #(
    parameter int N_CLASSES = 10,
    parameter int SCORE_W   = 2,
    parameter int N_MEMBERS = 4
) (
    input logic               clk,
    input logic               rst,
    ens_vote_argmax_if.slave  bus
);
    localparam int ACC_W  = SCORE_W + $clog2(N_MEMBERS);
    localparam int CLS_W  = (N_CLASSES > 1) ? $clog2(N_CLASSES) : 1;
    localparam int MCNT_W = (N_MEMBERS > 1) ? $clog2(N_MEMBERS) : 1;
    localparam logic [CLS_W-1:0]  LAST_IDX = CLS_W'(N_CLASSES - 1);
    localparam logic [MCNT_W-1:0] LAST_MBR = MCNT_W'(N_MEMBERS - 1);

    typedef enum logic [1:0] {ACCUM, SCAN, DONE} state_t;

    state_t              state, state_nxt;
    logic [ACC_W-1:0]    acc [N_CLASSES];
    logic [MCNT_W-1:0]   mcnt;
    logic [CLS_W-1:0]    idx;
    logic [CLS_W-1:0]    best_class, cand_class;
    logic [ACC_W-1:0]    best_score, cand_score;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ACCUM;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt     = state;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        case (state)
            ACCUM: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid && (mcnt == LAST_MBR)) state_nxt = SCAN;
            end
            SCAN: begin
                if (idx == LAST_IDX) state_nxt = DONE;
            end
            DONE: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) state_nxt = ACCUM;
            end
            default: state_nxt = ACCUM;
        endcase
    end

    // Strict compare keeps the earlier (lower) index on equal sums.
    always_comb begin
        cand_class = best_class;
        cand_score = best_score;
        if (acc[idx] > best_score) begin
            cand_class = idx;
            cand_score = acc[idx];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < N_CLASSES; c++) acc[c] <= '0;
            mcnt          <= '0;
            idx           <= '0;
            best_class    <= '0;
            best_score    <= '0;
            bus.out_class <= '0;
            bus.out_score <= '0;
        end else begin
            case (state)
                ACCUM: begin
                    if (bus.in_valid) begin
                        for (int c = 0; c < N_CLASSES; c++)
                            acc[c] <= acc[c] + ACC_W'(bus.in_scores[c*SCORE_W +: SCORE_W]);
                        if (mcnt == LAST_MBR) begin
                            mcnt       <= '0;
                            idx        <= '0;
                            best_class <= '0;
                            best_score <= '0;
                        end else begin
                            mcnt <= mcnt + 1'b1;
                        end
                    end
                end
                SCAN: begin
                    best_class <= cand_class;
                    best_score <= cand_score;
                    idx        <= idx + 1'b1;
                    if (idx == LAST_IDX) begin
                        bus.out_class <= cand_class;
                        bus.out_score <= cand_score;
                    end
                end
                DONE: begin
                    if (bus.out_ready)
                        for (int c = 0; c < N_CLASSES; c++) acc[c] <= '0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_ens_vote_argmax.sv
// Directed and reference-model checks of the ensemble vote/argmax block.
module tb_ens_vote_argmax;
    localparam int NC = 10;
    localparam int SW = 2;
    localparam int NM = 4;
    localparam int IW = NC * SW;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ens_vote_argmax_if #(.N_CLASSES(NC), .SCORE_W(SW), .N_MEMBERS(NM)) bus ();

    ens_vote_argmax #(.N_CLASSES(NC), .SCORE_W(SW), .N_MEMBERS(NM)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_assert = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [IW-1:0] one_hot(input int c, input int v);
        logic [IW-1:0] r;
        r = '0;
        r[c*SW +: SW] = SW'(v);
        return r;
    endfunction

    // Called at a negedge; presents one member for exactly one rising edge.
    task automatic feed(input logic [IW-1:0] s, input string tag);
        check({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
        bus.in_valid  = 1'b1;
        bus.in_scores = s;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.in_scores = IW'($urandom);
    endtask

    task automatic wait_done(output int edges);
        edges = 0;
        while (bus.out_valid !== 1'b1 && edges < 64) begin
            @(posedge clk);
            @(negedge clk);
            edges++;
        end
    endtask

    task automatic take(input string tag, input int ec, input int es);
        check({tag, "_out_valid"}, 32'(bus.out_valid), 32'd1);
        check({tag, "_class"}, 32'(bus.out_class), ec);
        check({tag, "_score"}, 32'(bus.out_score), es);
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.out_ready = 1'b0;
        check({tag, "_ready_after"}, 32'(bus.in_ready), 32'd1);
        check({tag, "_valid_after"}, 32'(bus.out_valid), 32'd0);
    endtask

    task automatic infer(input logic [IW-1:0] m0, input logic [IW-1:0] m1,
                         input logic [IW-1:0] m2, input logic [IW-1:0] m3,
                         input string tag, input int ec, input int es);
        int edges;
        feed(m0, tag);
        feed(m1, tag);
        feed(m2, tag);
        feed(m3, tag);
        wait_done(edges);
        check({tag, "_latency"}, edges, NC);
        take(tag, ec, es);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, n_assert %0d", n_assert);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [IW-1:0] s;
        int            edges;
        int            sum [NC];
        int            bc, bs;

        bus.in_valid  = 1'b0;
        bus.in_scores = '0;
        bus.out_ready = 1'b0;

        // Reset applied before any clock edge
        #2;
        check("rst_in_ready",  32'(bus.in_ready),  32'd1);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_class", 32'(bus.out_class), 32'd0);
        check("rst_out_score", 32'(bus.out_score), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Single dominant class, starting on the first edge after release
        infer(one_hot(7, 3), one_hot(7, 3), one_hot(7, 3), one_hot(7, 3), "c7", 7, 12);

        // Tie between classes 2 and 5 at 6; lower index wins
        infer(one_hot(2, 3) | one_hot(5, 3), one_hot(2, 3) | one_hot(5, 3),
              one_hot(0, 1), one_hot(9, 2), "tie", 2, 6);

        // All zero
        infer('0, '0, '0, '0, "zero", 0, 0);

        // Hold DONE with out_ready low while in_valid stays high
        s = one_hot(4, 2) | one_hot(1, 1);
        feed(s, "stall");
        feed(s, "stall");
        feed(s, "stall");
        feed(s, "stall");
        wait_done(edges);
        check("stall_latency", edges, NC);
        bus.in_valid  = 1'b1;
        bus.in_scores = '1;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            @(negedge clk);
            check("stall_out_valid", 32'(bus.out_valid), 32'd1);
            check("stall_in_ready",  32'(bus.in_ready),  32'd0);
            check("stall_class",     32'(bus.out_class), 32'd4);
            check("stall_score",     32'(bus.out_score), 32'd8);
        end
        bus.in_valid = 1'b0;
        take("stall", 4, 8);
        infer(one_hot(3, 1), one_hot(3, 1), one_hot(3, 1), one_hot(3, 1), "post_stall", 3, 4);

        // Reset during SCAN
        feed(one_hot(0, 3), "scan_rst");
        feed(one_hot(0, 3), "scan_rst");
        feed(one_hot(0, 3), "scan_rst");
        feed(one_hot(0, 3), "scan_rst");
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("scan_rst_in_ready",  32'(bus.in_ready),  32'd1);
        check("scan_rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("scan_rst_out_class", 32'(bus.out_class), 32'd0);
        check("scan_rst_out_score", 32'(bus.out_score), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        infer(one_hot(9, 1), one_hot(9, 1), one_hot(9, 1), one_hot(9, 1), "after_scan_rst", 9, 4);

        // Reset mid-ACCUM after two members
        feed(one_hot(0, 3), "accum_rst");
        feed(one_hot(0, 3), "accum_rst");
        rst = 1'b1;
        #1;
        check("accum_rst_in_ready", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        infer(one_hot(6, 2), one_hot(6, 2), one_hot(6, 2), one_hot(6, 2), "after_accum_rst", 6, 8);

        // Reset while holding a result in DONE
        feed(one_hot(5, 1), "done_rst");
        feed(one_hot(5, 1), "done_rst");
        feed(one_hot(5, 1), "done_rst");
        feed(one_hot(5, 1), "done_rst");
        wait_done(edges);
        check("done_rst_reached", 32'(bus.out_valid), 32'd1);
        #1;
        rst = 1'b1;
        #1;
        check("done_rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("done_rst_out_class", 32'(bus.out_class), 32'd0);
        check("done_rst_in_ready",  32'(bus.in_ready),  32'd1);
        @(negedge clk);
        rst = 1'b0;
        infer(one_hot(8, 3), one_hot(8, 3), one_hot(8, 3), one_hot(8, 3), "after_done_rst", 8, 12);

        // Random traffic with gaps on both sides against a sum-and-argmax model
        for (int inf = 0; inf < 1000; inf++) begin
            for (int c = 0; c < NC; c++) sum[c] = 0;
            for (int m = 0; m < NM; m++) begin
                repeat ($urandom_range(0, 2)) begin
                    bus.in_scores = IW'($urandom);
                    @(posedge clk);
                    @(negedge clk);
                end
                s = IW'($urandom);
                for (int c = 0; c < NC; c++) sum[c] += int'(s[c*SW +: SW]);
                feed(s, "rand");
            end
            wait_done(edges);
            check("rand_latency", edges, NC);
            bc = 0;
            bs = sum[0];
            for (int c = 1; c < NC; c++) begin
                if (sum[c] > bs) begin
                    bs = sum[c];
                    bc = c;
                end
            end
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                @(negedge clk);
            end
            take("rand", bc, bs);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
